ng_crg_bank: RTL and testbench

NG_CRG_BANK -- requirements
Module: ng_crg_bank

---
 rtl/ng_crg_bank.sv | 162 ++++++++++++++++
 tb/tb_ng_crg_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ng_crg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | ng_crg_bank: central register bank (A, Q, Z, LP, general) with an A:LP shifter. |
// | The shift engine is present only when CRG_SHIFT_ENGINE_EN is defined. Rev 1.0  |
// +--------------------------------------------------------------------------------+
module ng_crg_bank #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int CNTW  = 5,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  CLK2,
  input  logic                  GENRST,
  input  logic                  WR_EN,
  input  logic [AW-1:0]         WR_ADDR,
  input  logic                  WALP,
  input  logic                  WLP,
  input  logic [WIDTH-1:0]      WRITE_BUS,
  input  logic                  SH_REQ,
  input  logic [CNTW-1:0]       SH_CNT,
  output logic [NREG*WIDTH-1:0] REG_BUS,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CONFLICT
);

  localparam int IDX_A  = 0;
  localparam int IDX_LP = 3;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             busy_w;

  logic             wr_a_ok_w;
  logic             wr_lp_ok_w;
  logic             walp_ok_w;
  logic [WIDTH-1:0] bus_a_form_w;
  logic [WIDTH-1:0] bus_lp_form_w;
  logic [WIDTH-1:0] step_a_w;
  logic [WIDTH-1:0] step_lp_w;

  // A and LP are owned by the shifter while it runs; their writes are only honoured when idle.
  assign wr_a_ok_w  = WR_EN && (WR_ADDR == AW'(IDX_A)) && !busy_w;
  assign wr_lp_ok_w = ((WR_EN && (WR_ADDR == AW'(IDX_LP))) || WLP) && !busy_w;
  assign walp_ok_w  = WALP && !busy_w;

  assign bus_a_form_w  = {WRITE_BUS[WIDTH-1], WRITE_BUS[WIDTH-1], WRITE_BUS[WIDTH-2:1]};
  assign bus_lp_form_w = {WRITE_BUS[0], WRITE_BUS[0], walp_ok_w & WRITE_BUS[0],
                          WRITE_BUS[WIDTH-3:1]};

  assign step_a_w  = {regs_q[IDX_A][WIDTH-1], regs_q[IDX_A][WIDTH-1], regs_q[IDX_A][WIDTH-2:1]};
  assign step_lp_w = {regs_q[IDX_A][0], regs_q[IDX_A][0], regs_q[IDX_A][0],
                      regs_q[IDX_LP][WIDTH-3:1]};

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (WR_EN && (WR_ADDR == AW'(i)) && (i != IDX_A) && (i != IDX_LP)) begin
        regs_d[i] = WRITE_BUS;
      end
    end
    if (busy_w) begin
      regs_d[IDX_A]  = step_a_w;
      regs_d[IDX_LP] = step_lp_w;
    end else begin
      if (wr_a_ok_w) begin
        regs_d[IDX_A] = WRITE_BUS;
      end else if (walp_ok_w) begin
        regs_d[IDX_A] = bus_a_form_w;
      end
      if (wr_lp_ok_w) begin
        regs_d[IDX_LP] = bus_lp_form_w;
      end else if (walp_ok_w) begin
        regs_d[IDX_LP][WIDTH-3] = WRITE_BUS[0];
      end
    end
  end

  always_ff @(posedge CLK2) begin
    for (int i = 0; i < NREG; i++) begin
      if (GENRST) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_pack
    assign REG_BUS[g*WIDTH +: WIDTH] = regs_q[g];
  end

`ifdef CRG_SHIFT_ENGINE_EN
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            conflict_q, conflict_d;

  always_ff @(posedge CLK2) begin
    if (GENRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    conflict_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (SH_REQ) begin
          if (SH_CNT == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_SHIFT;
            cnt_d   = SH_CNT;
          end
        end
      end
      S_SHIFT: begin
        conflict_d = (WR_EN && ((WR_ADDR == AW'(IDX_A)) || (WR_ADDR == AW'(IDX_LP))))
                     || WALP || WLP;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_w   = (state_q == S_SHIFT);
  assign BUSY     = busy_w;
  assign DONE     = done_q;
  assign CONFLICT = conflict_q;
`else
  logic unused_sh_w;

  assign unused_sh_w = ^{SH_REQ, SH_CNT};
  assign busy_w      = 1'b0;
  assign BUSY        = 1'b0;
  assign DONE        = 1'b0;
  assign CONFLICT    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ng_crg_bank.sv
`default_nettype none
// tb_ng_crg_bank: directed and randomized checks of ng_crg_bank against a behavioural model.
module tb_ng_crg_bank;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, wr_en, walp, wlp, sh_req;
  logic [2:0]     wr_addr;
  logic [W-1:0]   bus;
  logic [CW-1:0]  sh_cnt;
  logic [N*W-1:0] reg_bus;
  logic           busy, done, conflict;

  ng_crg_bank #(.WIDTH(W), .NREG(N), .CNTW(CW)) dut (
    .CLK2(clk), .GENRST(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WALP(walp), .WLP(wlp),
    .WRITE_BUS(bus), .SH_REQ(sh_req), .SH_CNT(sh_cnt),
    .REG_BUS(reg_bus), .BUSY(busy), .DONE(done), .CONFLICT(conflict)
  );

  logic [W-1:0] m_reg [N];
  logic [W-1:0] n_reg [N];
  int           m_left = 0, n_left;
  logic         m_done = 1'b0, m_conf = 1'b0, n_done, n_conf;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] asr1(input logic [W-1:0] v);
    return W'($signed(v) >>> 1);
  endfunction

  // LP image of a bus word: sign-fill of bus[0] on top two bits, bit W-3 clear, bus/2 below
  function automatic logic [W-1:0] lp_form(input logic [W-1:0] v);
    return ((v >> 1) & 16'h1FFF) | (v[0] ? 16'hC000 : 16'h0000);
  endfunction

  function automatic logic [W-1:0] lp_step(input logic [W-1:0] lp, input logic a0);
    return ((lp >> 1) & 16'h1FFF) | (a0 ? 16'hE000 : 16'h0000);
  endfunction

  task automatic predict();
    bit eng_busy;
    n_reg  = m_reg;
    n_left = m_left;
    n_done = 1'b0;
    n_conf = 1'b0;
    eng_busy = (m_left > 0);
    if (rst) begin
      foreach (n_reg[i]) n_reg[i] = '0;
      n_left = 0;
    end else begin
      if (wr_en && wr_addr != 3'd0 && wr_addr != 3'd3) n_reg[wr_addr] = bus;
      if (eng_busy) begin
        n_reg[0] = asr1(m_reg[0]);
        n_reg[3] = lp_step(m_reg[3], m_reg[0][0]);
        n_left   = m_left - 1;
        n_done   = (n_left == 0);
        n_conf   = (wr_en && (wr_addr == 3'd0 || wr_addr == 3'd3)) || walp || wlp;
      end else begin
        if (wr_en && wr_addr == 3'd0) n_reg[0] = bus;
        else if (walp) n_reg[0] = asr1(bus);
        if ((wr_en && wr_addr == 3'd3) || wlp)
          n_reg[3] = lp_form(bus) | ((walp && bus[0]) ? 16'h2000 : 16'h0000);
        else if (walp)
          n_reg[3] = (m_reg[3] & ~16'h2000) | (bus[0] ? 16'h2000 : 16'h0000);
`ifdef CRG_SHIFT_ENGINE_EN
        if (sh_req) begin
          if (sh_cnt == '0) n_done = 1'b1;
          else n_left = int'(sh_cnt);
        end
`endif
      end
    end
  endtask

  task automatic cycle();
    logic [N*W-1:0] exp_bus;
    predict();
    @(posedge clk);
    #1;
    m_reg  = n_reg;
    m_left = n_left;
    m_done = n_done;
    m_conf = n_conf;
    for (int i = 0; i < N; i++) exp_bus[i*W +: W] = m_reg[i];
    chk("reg_bus", reg_bus, exp_bus);
    chk("busy", (N*W)'(busy), (N*W)'(m_left > 0));
    chk("done", (N*W)'(done), (N*W)'(m_done));
    chk("conflict", (N*W)'(conflict), (N*W)'(m_conf));
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; walp = 1'b0; wlp = 1'b0; sh_req = 1'b0;
    wr_addr = '0; bus = '0; sh_cnt = '0;
  endtask

  initial begin
    foreach (m_reg[i]) m_reg[i] = '0;
    idle();
    rst = 1'b1;
    cycle();
    idle();
    chk("reset_regs", reg_bus, '0);
    chk("reset_flags", (N*W)'({busy, done, conflict}), '0);

    wr_en = 1'b1; wr_addr = 3'd1; bus = 16'h1234;
    cycle(); idle();
    chk("q_write", (N*W)'(reg_bus[31:16]), (N*W)'(16'h1234));

    rst = 1'b1; cycle(); idle();
    walp = 1'b1; bus = 16'h8003;
    cycle(); idle();
    chk("walp_a", (N*W)'(reg_bus[15:0]), (N*W)'(16'hC001));
    chk("walp_lp", (N*W)'(reg_bus[63:48]), (N*W)'(16'h2000));

    wr_en = 1'b1; wr_addr = 3'd3; bus = 16'h0003;
    cycle(); idle();
    chk("lp_write", (N*W)'(reg_bus[63:48]), (N*W)'(16'hC001));

    // WR_EN to A wins over WALP for A; LP still takes bus[0] into bit W-3
    rst = 1'b1; cycle(); idle();
    wr_en = 1'b1; wr_addr = 3'd0; walp = 1'b1; bus = 16'h4005;
    cycle(); idle();
    chk("wr_a_prio", (N*W)'(reg_bus[15:0]), (N*W)'(16'h4005));
    chk("wr_a_prio_lp", (N*W)'(reg_bus[63:48]), (N*W)'(16'h2000));

`ifdef CRG_SHIFT_ENGINE_EN
    rst = 1'b1; cycle(); idle();
    wr_en = 1'b1; wr_addr = 3'd0; bus = 16'h0001;
    cycle(); idle();
    sh_req = 1'b1; sh_cnt = 5'd1;
    cycle(); idle();
    chk("sh1_busy", (N*W)'(busy), (N*W)'(1'b1));
    cycle();
    chk("sh1_a", (N*W)'(reg_bus[15:0]), (N*W)'(16'h0000));
    chk("sh1_lp", (N*W)'(reg_bus[63:48]), (N*W)'(16'hE000));
    chk("sh1_done", (N*W)'({busy, done}), (N*W)'(2'b01));
    cycle();
    chk("sh1_done_end", (N*W)'(done), (N*W)'(1'b0));

    rst = 1'b1; cycle(); idle();
    wr_en = 1'b1; wr_addr = 3'd0; bus = 16'h0100;
    cycle(); idle();
    sh_req = 1'b1; sh_cnt = 5'd4;
    cycle(); idle();
    wr_en = 1'b1; wr_addr = 3'd0; bus = 16'hFFFF;
    cycle(); idle();
    chk("sh4_conflict", (N*W)'(conflict), (N*W)'(1'b1));
    chk("sh4_a_kept", (N*W)'(reg_bus[15:0]), (N*W)'(16'h0080));
    wr_en = 1'b1; wr_addr = 3'd2; bus = 16'hFFFF;
    cycle(); idle();
    chk("sh4_z", (N*W)'(reg_bus[47:32]), (N*W)'(16'hFFFF));
    chk("sh4_no_conflict", (N*W)'(conflict), (N*W)'(1'b0));
    cycle();
    cycle();
    chk("sh4_done", (N*W)'({busy, done}), (N*W)'(2'b01));
    chk("sh4_a_final", (N*W)'(reg_bus[15:0]), (N*W)'(16'h0010));

    sh_req = 1'b1; sh_cnt = 5'd0;
    cycle(); idle();
    chk("sh0_done", (N*W)'({busy, done}), (N*W)'(2'b01));

    sh_req = 1'b1; sh_cnt = 5'd3;
    cycle(); idle();
    rst = 1'b1;
    cycle(); idle();
    cycle();
    chk("abort_no_done", (N*W)'({busy, done}), (N*W)'(2'b00));
`else
    sh_req = 1'b1; sh_cnt = 5'd3;
    cycle(); idle();
    chk("no_engine_busy", (N*W)'({busy, done, conflict}), '0);
`endif

    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(0, 49) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      walp    = ($urandom_range(0, 5) == 0);
      wlp     = ($urandom_range(0, 7) == 0);
      sh_req  = ($urandom_range(0, 4) == 0);
      sh_cnt  = 5'($urandom_range(0, 6));
      bus     = 16'($urandom);
      cycle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
